// File: rtl/rms_norm_stream_ctrl_pkg.sv
// Shared fixed-point definitions for the RMS-norm datapath and its stream controller.
package rms_norm_stream_ctrl_pkg;

    localparam int FXP_N     = 16;
    localparam int ARR_WIDTH = 8;
    localparam int TIMEOUT   = 1024;

    typedef logic signed [FXP_N-1:0]    fxp_t;
    typedef logic [ARR_WIDTH-1:0][FXP_N-1:0] vec_t;

endpackage

// File: rtl/rms_norm_stream_ctrl_if.sv
// Stream-in, engine start/done and stream-out signals of the RMS-norm stream controller.
interface rms_norm_stream_ctrl_if #(
    parameter int ARR_WIDTH = rms_norm_stream_ctrl_pkg::ARR_WIDTH,
    parameter int FXP_N     = rms_norm_stream_ctrl_pkg::FXP_N
);
    logic signed [FXP_N-1:0]           in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [ARR_WIDTH-1:0][FXP_N-1:0]   scale_arr;

    logic                              norm_start;
    logic                              norm_enable;
    logic [ARR_WIDTH-1:0][FXP_N-1:0]   norm_in_arr;
    logic [ARR_WIDTH-1:0][FXP_N-1:0]   norm_scale_arr;
    logic [ARR_WIDTH-1:0][FXP_N-1:0]   norm_out_arr;
    logic                              norm_done;

    logic [FXP_N-1:0]                  out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;
    logic                              err;

    // controller side
    modport slave (
        input  in_data, in_valid, scale_arr, norm_out_arr, norm_done, out_ready,
        output in_ready, norm_start, norm_enable, norm_in_arr, norm_scale_arr,
               out_data, out_valid, out_last, err
    );

    // environment side: upstream source, engine and downstream sink
    modport master (
        output in_data, in_valid, scale_arr, norm_out_arr, norm_done, out_ready,
        input  in_ready, norm_start, norm_enable, norm_in_arr, norm_scale_arr,
               out_data, out_valid, out_last, err
    );
endinterface

// File: rtl/rms_norm_stream_ctrl.sv
// Packs a stream of elements into a vector, launches the norm engine, and streams the
// captured result back out. Elements pass through bit-exact.
module rms_norm_stream_ctrl
    import rms_norm_stream_ctrl_pkg::*;
#(
    parameter int ARR_WIDTH = rms_norm_stream_ctrl_pkg::ARR_WIDTH,
    parameter int FXP_N     = rms_norm_stream_ctrl_pkg::FXP_N,
    parameter int TIMEOUT   = rms_norm_stream_ctrl_pkg::TIMEOUT
) (
    input logic                   clk,
    input logic                   rst,
    rms_norm_stream_ctrl_if.slave bus
);
    localparam int IW = $clog2(ARR_WIDTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] LAST  = IW'(ARR_WIDTH - 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   idx_q;
    logic [CW-1:0]                   tcnt_q;
    logic [ARR_WIDTH-1:0][FXP_N-1:0] in_arr_q, scale_q, outbuf_q;
    logic                            err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:   if (bus.in_valid && idx_q == LAST) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.norm_done)        state_d = S_DRAIN;
                else if (tcnt_q == TLAST) state_d = S_FILL;
            end
            S_DRAIN:  if (bus.out_ready && idx_q == LAST) state_d = S_FILL;
            default:  state_d = S_FILL;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == S_FILL);
        bus.norm_start  = (state_q == S_LAUNCH);
        bus.norm_enable = (state_q == S_LAUNCH) || (state_q == S_WAIT);
        bus.out_valid   = (state_q == S_DRAIN);
        bus.out_last    = (state_q == S_DRAIN) && (idx_q == LAST);
        // buffer resets to zero and idx to 0, so out_data reads 0 out of reset
        bus.out_data    = outbuf_q[idx_q];
    end

    // Datapath: slot index, timeout counter and vector registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            tcnt_q   <= '0;
            in_arr_q <= '0;
            scale_q  <= '0;
            outbuf_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_FILL: if (bus.in_valid) begin
                    in_arr_q[idx_q] <= bus.in_data;
                    if (idx_q == '0) scale_q <= bus.scale_arr;
                    idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
                S_LAUNCH: tcnt_q <= '0;
                S_WAIT: begin
                    if (bus.norm_done) begin
                        outbuf_q <= bus.norm_out_arr;
                    end else if (tcnt_q == TLAST) begin
                        // abandon this vector; operands are overwritten by the next fill
                        err_q <= 1'b1;
                        idx_q <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_DRAIN: if (bus.out_ready) idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.norm_in_arr    = in_arr_q;
    assign bus.norm_scale_arr = scale_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_rms_norm_stream_ctrl.sv
// Bench for rms_norm_stream_ctrl with a 10-cycle behavioural engine returning in+scale.
module tb_rms_norm_stream_ctrl;
    localparam int AW = 4;
    localparam int N  = 16;
    localparam int TO = 16;
    typedef logic [AW-1:0][N-1:0] vec_t;
    localparam vec_t GARBAGE = {AW{16'hDEAD}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rms_norm_stream_ctrl_if #(.ARR_WIDTH(AW), .FXP_N(N)) bus();
    rms_norm_stream_ctrl #(.ARR_WIDTH(AW), .FXP_N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int starts = 0;

    // engine model: launch latches in+scale, done pulses ~10 cycles later unless muted
    int   eng_cnt  = 0;
    logic eng_done = 1'b0;
    vec_t eng_res  = '0;
    logic eng_mute = 1'b0;
    logic spur_fill = 1'b0, spur_launch = 1'b0;
    logic spur;

    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (bus.norm_start) begin
            eng_cnt <= 10;
            for (int i = 0; i < AW; i++) eng_res[i] <= bus.norm_in_arr[i] + bus.norm_scale_arr[i];
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !eng_mute) eng_done <= 1'b1;
        end
    end

    always @(posedge clk) if (bus.norm_start && !rst) starts <= starts + 1;

    assign spur             = (spur_fill && bus.in_ready) || (spur_launch && bus.norm_start);
    assign bus.norm_done    = eng_done | spur;
    assign bus.norm_out_arr = spur ? GARBAGE : eng_res;

    function automatic vec_t ref_result(input vec_t d, input vec_t s);
        vec_t r;
        for (int i = 0; i < AW; i++) r[i] = d[i] + s[i];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < AW; i++) r[i] = N'($urandom);
        return r;
    endfunction

    // Feeds one vector starting at a negedge; returns at the negedge after the last accept.
    task automatic send_vec(input vec_t d, input vec_t s, input bit gaps, input bit scramble);
        int g, t;
        for (int i = 0; i < AW; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = N'($urandom);
                    if (scramble && i > 0) bus.scale_arr = rand_vec();
                    @(negedge clk);
                end
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = d[i];
            bus.scale_arr = (i == 0 || !scramble) ? s : rand_vec();
            t = 0;
            while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL send_ready elem=%0d in_ready=%b want 1", i, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Waits for the drain and consumes AW elements with random stalls.
    task automatic recv_vec(input vec_t exp, input int stall_pct);
        int k, t;
        k = 0; t = 0;
        while (!bus.out_valid && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL recv_wait out_valid=%b want 1", bus.out_valid);
        end else begin
            while (k < AW && t < 1000) begin
                bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k] ||
                    bus.out_last !== (k == AW - 1) || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL drain[%0d] valid=%b data=%h last=%b in_ready=%b want 1 %h %b 0",
                             k, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready,
                             exp[k], (k == AW - 1));
                end
                @(negedge clk); t++;
                if (bus.out_ready) k++;
            end
            bus.out_ready = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || k != AW) begin
                errors++;
                $display("FAIL drain_end out_valid=%b in_ready=%b taken=%0d want 0 1 %0d",
                         bus.out_valid, bus.in_ready, k, AW);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.norm_start, bus.norm_enable, bus.out_valid, bus.out_last, bus.err} !== 6'b100000 ||
            bus.out_data !== '0 || bus.norm_in_arr !== '0 || bus.norm_scale_arr !== '0) begin
            errors++;
            $display("FAIL reset_vals flags=%b out_data=%h in_arr=%h scale=%h want 100000 0 0 0",
                     {bus.in_ready, bus.norm_start, bus.norm_enable, bus.out_valid, bus.out_last, bus.err},
                     bus.out_data, bus.norm_in_arr, bus.norm_scale_arr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        vec_t d, s;
        int s0;
        for (int i = 0; i < AW; i++) begin d[i] = N'((i + 1) << 8); s[i] = 16'h0001; end
        s0 = starts;
        send_vec(d, s, 1'b0, 1'b0);
        checks++;
        if (bus.norm_start !== 1'b1 || bus.norm_enable !== 1'b1 || starts != s0) begin
            errors++;
            $display("FAIL basic_launch start=%b enable=%b pulses=%0d want 1 1 %0d",
                     bus.norm_start, bus.norm_enable, starts, s0);
        end
        checks++;
        if (bus.norm_in_arr !== d || bus.norm_scale_arr !== s) begin
            errors++;
            $display("FAIL basic_operands in=%h scale=%h want %h %h", bus.norm_in_arr, bus.norm_scale_arr, d, s);
        end
        @(negedge clk);
        checks++;
        if (bus.norm_start !== 1'b0 || bus.norm_enable !== 1'b1) begin
            errors++;
            $display("FAIL basic_wait start=%b enable=%b want 0 1", bus.norm_start, bus.norm_enable);
        end
        recv_vec(ref_result(d, s), 0);
        checks++;
        if (starts != s0 + 1 || bus.norm_in_arr !== d) begin
            errors++;
            $display("FAIL basic_pulses pulses=%0d in=%h want %0d %h", starts, bus.norm_in_arr, s0 + 1, d);
        end
    endtask

    task automatic test_stall();
        vec_t d, s;
        for (int r = 0; r < 3; r++) begin
            d = rand_vec(); s = rand_vec();
            send_vec(d, s, 1'b0, 1'b0);
            recv_vec(ref_result(d, s), 50);
        end
    endtask

    task automatic test_gaps();
        vec_t d, s;
        for (int r = 0; r < 3; r++) begin
            d = rand_vec(); s = rand_vec();
            send_vec(d, s, 1'b1, 1'b1);
            checks++;
            if (bus.norm_in_arr !== d || bus.norm_scale_arr !== s) begin
                errors++;
                $display("FAIL gaps_operands in=%h scale=%h want %h %h", bus.norm_in_arr, bus.norm_scale_arr, d, s);
            end
            recv_vec(ref_result(d, s), 30);
        end
    endtask

    task automatic test_spurious();
        vec_t d, s;
        d = rand_vec(); s = rand_vec();
        spur_fill = 1'b1; spur_launch = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.norm_enable !== 1'b0) begin
            errors++;
            $display("FAIL spur_fill in_ready=%b enable=%b want 1 0", bus.in_ready, bus.norm_enable);
        end
        send_vec(d, s, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.norm_enable !== 1'b1 || bus.norm_start !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL spur_launch enable=%b start=%b out_valid=%b want 1 0 0",
                     bus.norm_enable, bus.norm_start, bus.out_valid);
        end
        recv_vec(ref_result(d, s), 0);
        spur_fill = 1'b0; spur_launch = 1'b0;
    endtask

    task automatic test_timeout();
        vec_t d, s;
        int waits;
        bit early;
        d = rand_vec(); s = rand_vec();
        eng_mute = 1'b1;
        send_vec(d, s, 1'b0, 1'b0);
        waits = 0; early = 1'b0;
        @(negedge clk);
        while (bus.norm_enable === 1'b1 && waits < 100) begin
            if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) early = 1'b1;
            waits++;
            @(negedge clk);
        end
        checks++;
        if (waits != TO || early) begin
            errors++;
            $display("FAIL timeout_len wait_cycles=%0d early_err_or_valid=%b want %0d 0", waits, early, TO);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort err=%b in_ready=%b out_valid=%b want 1 1 0",
                     bus.err, bus.in_ready, bus.out_valid);
        end
        eng_mute = 1'b0;
        d = rand_vec(); s = rand_vec();
        send_vec(d, s, 1'b0, 1'b0);
        recv_vec(ref_result(d, s), 20);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky err=%b want 1", bus.err);
        end
    endtask

    task automatic test_reset_mid();
        vec_t d, s;
        int t;
        bit bad;
        // reset while waiting on the engine; its late done must be ignored
        d = rand_vec(); s = rand_vec();
        send_vec(d, s, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.norm_start, bus.norm_enable, bus.out_valid, bus.out_last, bus.err} !== 6'b100000 ||
            bus.out_data !== '0 || bus.norm_in_arr !== '0 || bus.norm_scale_arr !== '0) begin
            errors++;
            $display("FAIL rst_wait flags=%b out_data=%h in_arr=%h scale=%h want 100000 0 0 0",
                     {bus.in_ready, bus.norm_start, bus.norm_enable, bus.out_valid, bus.out_last, bus.err},
                     bus.out_data, bus.norm_in_arr, bus.norm_scale_arr);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_late_done spurious out_valid or in_ready drop after reset, want none");
        end
        // reset in the middle of a drain
        d = rand_vec(); s = rand_vec();
        send_vec(d, s, 1'b0, 1'b0);
        t = 0;
        while (!bus.out_valid && t < 200) begin @(negedge clk); t++; end
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.norm_start, bus.norm_enable, bus.out_valid, bus.out_last, bus.err} !== 6'b100000 ||
            bus.out_data !== '0 || bus.norm_in_arr !== '0 || bus.norm_scale_arr !== '0) begin
            errors++;
            $display("FAIL rst_drain flags=%b out_data=%h in_arr=%h scale=%h want 100000 0 0 0",
                     {bus.in_ready, bus.norm_start, bus.norm_enable, bus.out_valid, bus.out_last, bus.err},
                     bus.out_data, bus.norm_in_arr, bus.norm_scale_arr);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d = rand_vec(); s = rand_vec();
        send_vec(d, s, 1'b0, 1'b0);
        recv_vec(ref_result(d, s), 25);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.scale_arr = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_gaps();
        test_spurious();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
